// File: rtl/vend_pkg.sv
// Shared definitions for the vending controller.
//   - coin face values in cents
//   - controller state encoding
//   - coin_value(): cents represented by a set of simultaneous coin pulses
package vend_pkg;

    localparam int unsigned VAL_NICKEL  = 5;
    localparam int unsigned VAL_DIME    = 10;
    localparam int unsigned VAL_QUARTER = 25;
    localparam int unsigned VAL_DOLLAR  = 100;

    typedef enum logic [1:0] {
        StIdle,
        StCollect,
        StDispense,
        StChange
    } vend_state_e;

    function automatic int unsigned coin_value(input logic nickel, input logic dime,
                                               input logic quarter, input logic dollar);
        return (nickel  ? VAL_NICKEL  : 0) + (dime   ? VAL_DIME   : 0) +
               (quarter ? VAL_QUARTER : 0) + (dollar ? VAL_DOLLAR : 0);
    endfunction

endpackage

// File: rtl/vend_change_gen.sv
// Greedy change emitter: one coin per cycle, quarters first, then dimes, then nickels.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   load, amount  load pulse with the amount to pay out (cents)
//   coin_q/d/n    one-hot eject of a quarter, dime or nickel
//   change_done   pulse in the cycle after the last coin (residue below 5 is dropped)
module vend_change_gen
    import vend_pkg::*;
#(
    parameter int unsigned PRICE_W = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [PRICE_W-1:0] amount,
    output logic               coin_q,
    output logic               coin_d,
    output logic               coin_n,
    output logic               change_done
);

    localparam logic [PRICE_W-1:0] QV = PRICE_W'(VAL_QUARTER);
    localparam logic [PRICE_W-1:0] DV = PRICE_W'(VAL_DIME);
    localparam logic [PRICE_W-1:0] NV = PRICE_W'(VAL_NICKEL);

    logic [PRICE_W-1:0] rem_q;
    logic               active_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q       <= '0;
            active_q    <= 1'b0;
            coin_q      <= 1'b0;
            coin_d      <= 1'b0;
            coin_n      <= 1'b0;
            change_done <= 1'b0;
        end else begin
            coin_q      <= 1'b0;
            coin_d      <= 1'b0;
            coin_n      <= 1'b0;
            change_done <= 1'b0;
            if (load) begin
                rem_q    <= amount;
                active_q <= 1'b1;
            end else if (active_q) begin
                if (rem_q >= QV) begin
                    coin_q <= 1'b1;
                    rem_q  <= rem_q - QV;
                end else if (rem_q >= DV) begin
                    coin_d <= 1'b1;
                    rem_q  <= rem_q - DV;
                end else if (rem_q >= NV) begin
                    coin_n <= 1'b1;
                    rem_q  <= rem_q - NV;
                end else begin
                    active_q    <= 1'b0;
                    rem_q       <= '0;
                    change_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/vend_ctrl_n.sv
// N-slot vending controller with cash (coin collection + change) and card-credit payment.
// Ports:
//   clk, rst                               clock, asynchronous active-high reset
//   sel_valid, sel_index, pay_credit,
//   credit_balance                         product selection and payment mode
//   nickel, dime, quarter, dollar, cancel  coin pulses and abort
//   price_bus                              flattened price table
//   restock_valid/index/count              stock reload (IDLE only)
//   dispense, dispense_index, credit_debit vend pulse, slot and card charge
//   coin_q, coin_d, coin_n, change_done    change / refund emission
//   reject, busy, inventory                status
module vend_ctrl_n
    import vend_pkg::*;
#(
    parameter int unsigned NUM_ITEMS = 8,
    parameter int unsigned PRICE_W   = 10,
    parameter int unsigned INV_W     = 3,
    parameter int unsigned TIMEOUT   = 40,
    localparam int unsigned IDX_W    = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sel_valid,
    input  logic [IDX_W-1:0]             sel_index,
    input  logic                         pay_credit,
    input  logic [PRICE_W-1:0]           credit_balance,
    input  logic                         nickel,
    input  logic                         dime,
    input  logic                         quarter,
    input  logic                         dollar,
    input  logic                         cancel,
    input  logic [NUM_ITEMS*PRICE_W-1:0] price_bus,
    input  logic                         restock_valid,
    input  logic [IDX_W-1:0]             restock_index,
    input  logic [INV_W-1:0]             restock_count,
    output logic                         dispense,
    output logic [IDX_W-1:0]             dispense_index,
    output logic [PRICE_W-1:0]           credit_debit,
    output logic                         coin_q,
    output logic                         coin_d,
    output logic                         coin_n,
    output logic                         change_done,
    output logic                         reject,
    output logic                         busy,
    output logic [NUM_ITEMS*INV_W-1:0]   inventory
);

    localparam int unsigned TMO_W   = $clog2(TIMEOUT + 1);
    localparam int unsigned ACC_MAX = (2 ** PRICE_W) - 1;

    vend_state_e        state_q;
    logic [INV_W-1:0]   inv_q [NUM_ITEMS];
    logic [IDX_W-1:0]   slot_q;
    logic [PRICE_W-1:0] price_q;
    logic [PRICE_W-1:0] acc_q;
    logic [PRICE_W-1:0] change_q;
    logic [TMO_W-1:0]   tmo_q;
    logic               auth_q;  // credit vend approved, dispense pulse still to come
    logic               load_q;

    logic               sel_in_range, rs_in_range, any_coin;
    logic [IDX_W-1:0]   sel_slot;
    logic [PRICE_W-1:0] sel_price, acc_new;
    logic [INV_W-1:0]   sel_stock;
    logic [31:0]        acc_sum;

    always_comb begin
        sel_in_range = 32'(sel_index) < NUM_ITEMS;
        rs_in_range  = 32'(restock_index) < NUM_ITEMS;
        sel_slot     = sel_in_range ? sel_index : '0;
        sel_price    = price_bus[32'(sel_slot)*PRICE_W +: PRICE_W];
        // A same-cycle restock of the selected slot is visible to the selection.
        sel_stock    = (restock_valid && rs_in_range && restock_index == sel_index) ?
                       restock_count : inv_q[sel_slot];
        any_coin     = nickel | dime | quarter | dollar;
        acc_sum      = 32'(acc_q) + coin_value(nickel, dime, quarter, dollar);
        acc_new      = (acc_sum > ACC_MAX) ? PRICE_W'(ACC_MAX) : PRICE_W'(acc_sum);
        inventory    = '0;
        for (int k = 0; k < NUM_ITEMS; k++) begin
            inventory[k*INV_W +: INV_W] = inv_q[k];
        end
    end

    assign busy = (state_q != StIdle);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StIdle;
            slot_q         <= '0;
            price_q        <= '0;
            acc_q          <= '0;
            change_q       <= '0;
            tmo_q          <= '0;
            auth_q         <= 1'b0;
            load_q         <= 1'b0;
            dispense       <= 1'b0;
            dispense_index <= '0;
            credit_debit   <= '0;
            reject         <= 1'b0;
            for (int i = 0; i < NUM_ITEMS; i++) inv_q[i] <= '1;
        end else begin
            dispense     <= 1'b0;
            reject       <= 1'b0;
            load_q       <= 1'b0;
            credit_debit <= '0;
            case (state_q)
                StIdle: begin
                    if (restock_valid && rs_in_range) inv_q[restock_index] <= restock_count;
                    if (sel_valid) begin
                        if (!sel_in_range || sel_stock == '0) begin
                            reject <= 1'b1;
                        end else if (pay_credit) begin
                            if (credit_balance >= sel_price) begin
                                slot_q   <= sel_slot;
                                price_q  <= sel_price;
                                change_q <= '0;
                                auth_q   <= 1'b1;
                                state_q  <= StDispense;
                            end else begin
                                reject <= 1'b1;
                            end
                        end else begin
                            slot_q  <= sel_slot;
                            price_q <= sel_price;
                            acc_q   <= '0;
                            tmo_q   <= '0;
                            state_q <= StCollect;
                        end
                    end
                end
                StCollect: begin
                    acc_q <= acc_new;
                    if (cancel) begin
                        change_q <= acc_new;
                        load_q   <= 1'b1;
                        state_q  <= StChange;
                    end else if (acc_new >= price_q) begin
                        // Cash vend pulses in the cycle right after the satisfying coin.
                        change_q       <= acc_new - price_q;
                        dispense       <= 1'b1;
                        dispense_index <= slot_q;
                        inv_q[slot_q]  <= inv_q[slot_q] - INV_W'(1);
                        auth_q         <= 1'b0;
                        state_q        <= StDispense;
                    end else if (any_coin) begin
                        tmo_q <= '0;
                    end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                        change_q <= acc_q;
                        load_q   <= 1'b1;
                        state_q  <= StChange;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                StDispense: begin
                    if (auth_q) begin
                        auth_q         <= 1'b0;
                        dispense       <= 1'b1;
                        dispense_index <= slot_q;
                        credit_debit   <= price_q;
                        inv_q[slot_q]  <= inv_q[slot_q] - INV_W'(1);
                    end else if (change_q != '0) begin
                        load_q  <= 1'b1;
                        state_q <= StChange;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StChange: begin
                    if (change_done) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    vend_change_gen #(
        .PRICE_W (PRICE_W)
    ) u_change (
        .clk         (clk),
        .rst         (rst),
        .load        (load_q),
        .amount      (change_q),
        .coin_q      (coin_q),
        .coin_d      (coin_d),
        .coin_n      (coin_n),
        .change_done (change_done)
    );

endmodule
